// File: rtl/boot_pkg.sv
// Shared boot-loader constants: FSM state encoding and UART protocol framing.
package boot_pkg;
  localparam logic [1:0] S_LEN  = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream in / instruction-memory write-port out bundle of the boot loader.
interface boot_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport slave  (input  rx_valid, rx_data, output imem_we, imem_addr, imem_wdata);
  modport master (output rx_valid, rx_data, input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/byte_packer.sv
// Little-endian 4-byte assembler; word_done/word are valid combinationally with the 4th byte.
module byte_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_done,
  output logic [31:0] word
);
  logic [1:0]  cnt;
  logic [23:0] buf_q;

  // Earlier bytes shift down so the first byte lands in bits 7:0.
  assign word_done = in_valid && (cnt == 2'(WORD_BYTES - 1));
  assign word      = {in_byte, buf_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      buf_q <= '0;
    end else if (in_valid) begin
      cnt   <= cnt + 2'd1;
      buf_q <= {in_byte, buf_q[23:8]};
    end
  end
endmodule

// File: rtl/boot_loader.sv
// UART boot loader: length header then N little-endian words written to imem, core held until done.
module boot_loader
  import boot_pkg::*;
#(
  parameter int          MEM_WORDS = 512,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  boot_loader_if.slave  bus,
  output logic          core_rst_n,
  output logic          boot_done,
  output logic          boot_err
);
  localparam int IDX_W = $clog2(MEM_WORDS) + 1;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] n_words;
  logic             pk_valid;
  logic             word_done;
  logic [31:0]      word;

  // Header and payload share one packer; terminal states stop feeding it.
  assign pk_valid = bus.rx_valid && (state == S_LEN || state == S_DATA);

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (pk_valid),
    .in_byte   (bus.rx_data),
    .word_done (word_done),
    .word      (word)
  );

  assign core_rst_n = (state == S_DONE);
  assign boot_done  = (state == S_DONE);
  assign boot_err   = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_LEN;
      idx            <= '0;
      n_words        <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (word_done) begin
        case (state)
          S_LEN: begin
            if (word == 32'd0)
              state <= S_DONE;
            else if (word > 32'(MEM_WORDS))
              state <= S_ERR;
            else begin
              state   <= S_DATA;
              idx     <= '0;
              n_words <= word[IDX_W-1:0];
            end
          end
          S_DATA: begin
            bus.imem_we    <= 1'b1;
            bus.imem_wdata <= word;
            bus.imem_addr  <= BASE_ADDR + (32'(idx) << 2);
            idx            <= idx + 1'b1;
            if (idx == n_words - 1'b1)
              state <= S_DONE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// Randomized byte-stream bench for boot_loader against a queue-based image model.
module tb_boot_loader;
  localparam int MEM_WORDS = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_rst_n, boot_done, boot_err;

  boot_loader_if bus();

  boot_loader #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .boot_done  (boot_done),
    .boot_err   (boot_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int hold_viol = 0;
  logic [7:0]  stim[$];
  logic [31:0] obs_addr[$], obs_data[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic [31:0] last_a = '0, last_d = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write capture plus hold-when-idle monitor.
  always @(negedge clk) begin
    if (rst_n && !bus.imem_we && (bus.imem_addr != last_a || bus.imem_wdata != last_d))
      hold_viol++;
    if (rst_n && bus.imem_we) begin
      obs_addr.push_back(bus.imem_addr);
      obs_data.push_back(bus.imem_wdata);
    end
    last_a = bus.imem_addr;
    last_d = bus.imem_wdata;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_rst_we"},    32'(bus.imem_we),    32'd0);
    check({tag, "_rst_addr"},  bus.imem_addr,       32'd0);
    check({tag, "_rst_wdata"}, bus.imem_wdata,      32'd0);
    check({tag, "_rst_done"},  32'(boot_done),      32'd0);
    check({tag, "_rst_err"},   32'(boot_err),       32'd0);
    check({tag, "_rst_core"},  32'(core_rst_n),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Model: header N, error if N>MEM_WORDS, else first N payload words go to 4*i.
  task automatic run_stream(input string tag, input int max_gap);
    logic [31:0] n;
    int nw, avail;
    bit exp_err, exp_done, exact;
    n = {stim[3], stim[2], stim[1], stim[0]};
    exp_err = (n > 32'(MEM_WORDS));
    avail = (stim.size() - 4) / 4;
    nw = exp_err ? 0 : ((int'(n) < avail) ? int'(n) : avail);
    exp_done = !exp_err && (int'(n) <= avail);
    exact = exp_done && (stim.size() == 4 + 4 * int'(n));
    exp_addr.delete(); exp_data.delete();
    for (int i = 0; i < nw; i++) begin
      exp_addr.push_back(32'(i * 4));
      exp_data.push_back({stim[7+4*i], stim[6+4*i], stim[5+4*i], stim[4+4*i]});
    end
    obs_addr.delete(); obs_data.delete();
    hold_viol = 0;
    for (int i = 0; i < stim.size(); i++) begin
      if (exact && i == stim.size() - 1) begin
        send_byte(stim[i], 0);
        check({tag, "_done_at_last"}, 32'(boot_done),  32'd1);
        check({tag, "_core_at_last"}, 32'(core_rst_n), 32'd1);
      end else begin
        send_byte(stim[i], (max_gap == 0) ? 0 : $urandom_range(0, max_gap));
        if (exact && i == stim.size() - 2)
          check({tag, "_done_early"}, 32'(boot_done), 32'd0);
      end
    end
    repeat (4) @(negedge clk);
    check({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(nw));
    for (int i = 0; i < nw && i < obs_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
      check($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
    end
    check({tag, "_done"}, 32'(boot_done),  32'(exp_done));
    check({tag, "_err"},  32'(boot_err),   32'(exp_err));
    check({tag, "_core"}, 32'(core_rst_n), 32'(exp_done));
    check({tag, "_hold"}, 32'(hold_viol),  32'd0);
  endtask

  task automatic load_image();
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
  endtask

  task automatic load_random(input logic [31:0] n, input int words);
    stim = '{n[7:0], n[15:8], n[23:16], n[31:24]};
    for (int i = 0; i < 4 * words; i++) stim.push_back(8'($urandom));
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge clk);
    do_reset("init");

    load_image();
    run_stream("image", 0);

    // Bytes after completion must change nothing.
    stim = '{8'hde, 8'had, 8'hbe, 8'hef, 8'h55};
    obs_addr.delete();
    for (int i = 0; i < stim.size(); i++) send_byte(stim[i], $urandom_range(0, 2));
    repeat (3) @(negedge clk);
    check("post_nwrites", 32'(obs_addr.size()), 32'd0);
    check("post_done",    32'(boot_done),       32'd1);
    check("post_addr",    bus.imem_addr,        32'h4);
    check("post_wdata",   bus.imem_wdata,       32'h0020_0593);
    do_reset("post");

    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_stream("zero", 0);
    do_reset("zero");

    stim = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_stream("ovf", 0);
    do_reset("ovf");

    load_image();
    run_stream("gaps", 7);
    do_reset("gaps");

    load_image();
    for (int i = 0; i < 6; i++) send_byte(stim[i], 0);
    do_reset("mid");
    run_stream("mid_reload", 3);
    do_reset("mid2");

    load_image();
    for (int i = 0; i < 5; i++) stim.push_back(8'($urandom));
    run_stream("img_extra", 2);
    do_reset("extra");

    for (int t = 0; t < 8; t++) begin
      int w;
      w = $urandom_range(1, 6);
      load_random(32'(w), w);
      run_stream($sformatf("rnd%0d", t), (t % 2 == 0) ? 0 : 7);
      do_reset($sformatf("rnd%0d", t));
    end

    load_random(32'(MEM_WORDS), MEM_WORDS);
    run_stream("full", 0);
    do_reset("full");

    load_random(32'(MEM_WORDS + 1), 2);
    run_stream("ovf513", 1);
    do_reset("ovf513");

    load_random(32'hFFFF_FFFF, 1);
    run_stream("ovfmax", 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
